// File: rtl/dm_responder_if.sv
// M-stage data-memory request/response bundle between the pipeline (master)
// and the data-memory responder (slave).
interface dm_responder_if;
    // Handshake: a request is accepted on a rising clk edge where req_valid and
    // req_ready are both 1. Request fields are sampled on that edge only and may
    // change afterwards. The response is the single cycle with rsp_valid=1; it
    // cannot be back-pressured, and rsp_rdata/rsp_err are 0 whenever rsp_valid=0.
    logic        req_valid;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        busy;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, req_pc,
        input  req_ready, busy, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, req_pc,
        output req_ready, busy, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed data RAM answering one M-stage load/store after LATENCY wait states.
// Optional macro DMRSP_TRACE_EN prints one line per committed store.
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus,
    output logic [1:0]    state_o
);
    localparam int unsigned IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] pc_q;
    logic        ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept;
    logic        enter_resp;
    logic        write_d;
    logic [31:0] addr_d;
    logic [31:0] wdata_d;
    logic [3:0]  be_d;
    logic [31:0] pc_d;
    logic [31:0] off_d;
    logic [31:0] idx_d;
    logic        err_d;
    logic [31:0] old_word;
    logic [31:0] merged_word;

    // The request view is the live inputs in the accept cycle, else the latched copy,
    // so a LATENCY==0 store can commit on the same edge that accepts it.
    always_comb begin
        accept     = (state_q == S_IDLE) && bus.req_valid;
        write_d    = accept ? bus.req_write : write_q;
        addr_d     = accept ? bus.req_addr  : addr_q;
        wdata_d    = accept ? bus.req_wdata : wdata_q;
        be_d       = accept ? bus.req_be    : be_q;
        pc_d       = accept ? bus.req_pc    : pc_q;
        off_d      = addr_d - BASE_ADDR;
        idx_d      = {2'b00, off_d[31:2]};
        err_d      = (addr_d[1:0] != 2'b00) || (idx_d >= DEPTH_WORDS);
        enter_resp = (accept && (LATENCY == 0)) || ((state_q == S_WAIT) && (cnt_q == 4'd0));
        old_word   = mem_q[idx_d[IW-1:0]];
        merged_word = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be_d[b]) merged_word[8*b +: 8] = wdata_d[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            be_q        <= 4'd0;
            pc_q        <= 32'd0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem_q[i] <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        write_q <= bus.req_write;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        be_q    <= bus.req_be;
                        pc_q    <= bus.req_pc;
                        ready_q <= 1'b0;
                        cnt_q   <= CNT_INIT;
                        state_q <= (LATENCY == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
            endcase
            if (enter_resp) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= err_d;
                rsp_rdata_q <= (!err_d && !write_d) ? old_word : 32'd0;
                if (!err_d && write_d && (be_d != 4'd0)) begin
                    mem_q[idx_d[IW-1:0]] <= merged_word;
`ifdef DMRSP_TRACE_EN
                    $display("%d@%h: *%h <= %h", $time, pc_d, {addr_d[31:2], 2'b00}, merged_word);
`endif
                end
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{off_d[1:0], pc_d};

    assign bus.req_ready = ready_q;
    assign bus.busy      = accept || (state_q == S_WAIT);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign state_o       = state_q;
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: LATENCY=2 instance (a) and LATENCY=0 instance (b).
module tb_dm_responder;
    logic clk;
    logic reset;
    logic [1:0] state_a;
    logic [1:0] state_b;
    int n_vec;
    int n_miss;

    dm_responder_if bus_a ();
    dm_responder_if bus_b ();

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2), .BASE_ADDR(32'h0)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_a.slave),
        .state_o (state_a)
    );

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(0), .BASE_ADDR(32'h0)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus_b.slave),
        .state_o (state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_a(input logic v, input logic w, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
        bus_a.req_valid = v;
        bus_a.req_write = w;
        bus_a.req_addr  = addr;
        bus_a.req_wdata = wd;
        bus_a.req_be    = be;
        bus_a.req_pc    = 32'h0000_1000 + addr;
    endtask

    // One full LATENCY=2 transaction on instance a; starts and ends at posedge+1 of an IDLE cycle.
    task automatic do_req_a(input string tag, input logic w, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] be,
                            input logic [31:0] exp_rdata, input logic exp_err);
        chk({tag, ".ready"}, 32'(bus_a.req_ready), 32'd1);
        set_a(1'b1, w, addr, wd, be);
        #2;
        chk({tag, ".busy0"}, 32'(bus_a.busy), 32'd1);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        chk({tag, ".busy1"}, 32'(bus_a.busy), 32'd1);
        chk({tag, ".novalid1"}, 32'(bus_a.rsp_valid), 32'd0);
        tick();
        #2;
        chk({tag, ".busy2"}, 32'(bus_a.busy), 32'd1);
        chk({tag, ".novalid2"}, 32'(bus_a.rsp_valid), 32'd0);
        tick();
        #2;
        chk({tag, ".valid"}, 32'(bus_a.rsp_valid), 32'd1);
        chk({tag, ".err"}, 32'(bus_a.rsp_err), 32'(exp_err));
        chk({tag, ".rdata"}, bus_a.rsp_rdata, exp_rdata);
        chk({tag, ".busy3"}, 32'(bus_a.busy), 32'd0);
        tick();
    endtask

    logic [31:0] b_addr [3];
    logic [31:0] b_exp  [3];

    initial begin
        n_vec  = 0;
        n_miss = 0;
        reset  = 1'b1;
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus_b.req_valid = 1'b0;
        bus_b.req_write = 1'b0;
        bus_b.req_addr  = 32'h0;
        bus_b.req_wdata = 32'h0;
        bus_b.req_be    = 4'h0;
        bus_b.req_pc    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        chk("rst.ready", 32'(bus_a.req_ready), 32'd1);
        chk("rst.busy", 32'(bus_a.busy), 32'd0);
        chk("rst.valid", 32'(bus_a.rsp_valid), 32'd0);
        chk("rst.rdata", bus_a.rsp_rdata, 32'd0);
        chk("rst.err", 32'(bus_a.rsp_err), 32'd0);
        chk("rst.state", 32'(state_a), 32'd0);
        tick();

        // Store with junk requests held valid during WAIT/RESP, which must be ignored.
        set_a(1'b1, 1'b1, 32'h10, 32'h1234_5678, 4'hF);
        #2;
        chk("t1.busy0", 32'(bus_a.busy), 32'd1);
        tick();
        set_a(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        #2;
        chk("t1.busy1", 32'(bus_a.busy), 32'd1);
        chk("t1.ready1", 32'(bus_a.req_ready), 32'd0);
        chk("t1.state1", 32'(state_a), 32'd1);
        tick();
        #2;
        chk("t1.busy2", 32'(bus_a.busy), 32'd1);
        chk("t1.novalid2", 32'(bus_a.rsp_valid), 32'd0);
        tick();
        #2;
        chk("t1.valid", 32'(bus_a.rsp_valid), 32'd1);
        chk("t1.err", 32'(bus_a.rsp_err), 32'd0);
        chk("t1.rdata", bus_a.rsp_rdata, 32'd0);
        chk("t1.busy3", 32'(bus_a.busy), 32'd0);
        chk("t1.ready3", 32'(bus_a.req_ready), 32'd0);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #2;
        chk("t1.pulse", 32'(bus_a.rsp_valid), 32'd0);
        chk("t1.idle", 32'(bus_a.req_ready), 32'd1);
        tick();

        do_req_a("t2.load", 1'b0, 32'h10, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
        do_req_a("t3.store", 1'b1, 32'h10, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
        do_req_a("t3.load", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);
        do_req_a("t4.misal", 1'b0, 32'h11, 32'h0, 4'hF, 32'h0, 1'b1);
        do_req_a("t4.range", 1'b1, 32'h3000, 32'hFFFF_FFFF, 4'hF, 32'h0, 1'b1);
        do_req_a("t4.be0", 1'b1, 32'h10, 32'h0000_0000, 4'h0, 32'h0, 1'b0);
        do_req_a("t4.reload", 1'b0, 32'h10, 32'h0, 4'h0, 32'h12BB_56DD, 1'b0);
        do_req_a("t4.laststore", 1'b1, 32'h2FFC, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
        do_req_a("t4.lastload", 1'b0, 32'h2FFC, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0);

        // Reset during the first WAIT cycle of a store.
        set_a(1'b1, 1'b1, 32'h20, 32'h5555_AAAA, 4'hF);
        tick();
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        reset = 1'b1;
        #2;
        chk("t5.inwait", 32'(state_a), 32'd1);
        tick();
        reset = 1'b0;
        #2;
        chk("t5.ready", 32'(bus_a.req_ready), 32'd1);
        chk("t5.novalid1", 32'(bus_a.rsp_valid), 32'd0);
        chk("t5.state", 32'(state_a), 32'd0);
        tick();
        chk("t5.novalid2", 32'(bus_a.rsp_valid), 32'd0);
        do_req_a("t5.load20", 1'b0, 32'h20, 32'h0, 4'h0, 32'h0, 1'b0);
        do_req_a("t5.load10", 1'b0, 32'h10, 32'h0, 4'h0, 32'h0, 1'b0);

        // LATENCY=0: one store, then three loads with req_valid held high.
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b1;
        bus_b.req_addr  = 32'h100;
        bus_b.req_wdata = 32'h0BAD_CAFE;
        bus_b.req_be    = 4'hF;
        #2;
        chk("t6.sbusy", 32'(bus_b.busy), 32'd1);
        tick();
        bus_b.req_valid = 1'b0;
        #2;
        chk("t6.svalid", 32'(bus_b.rsp_valid), 32'd1);
        chk("t6.serr", 32'(bus_b.rsp_err), 32'd0);
        tick();

        b_addr[0] = 32'h100; b_exp[0] = 32'h0BAD_CAFE;
        b_addr[1] = 32'h104; b_exp[1] = 32'h0000_0000;
        b_addr[2] = 32'h100; b_exp[2] = 32'h0BAD_CAFE;
        bus_b.req_valid = 1'b1;
        bus_b.req_write = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus_b.req_addr = b_addr[k];
            #2;
            chk($sformatf("t6.acc%0d.busy", k), 32'(bus_b.busy), 32'd1);
            chk($sformatf("t6.acc%0d.novalid", k), 32'(bus_b.rsp_valid), 32'd0);
            tick();
            bus_b.req_addr = 32'h3;
            #2;
            chk($sformatf("t6.rsp%0d.valid", k), 32'(bus_b.rsp_valid), 32'd1);
            chk($sformatf("t6.rsp%0d.rdata", k), bus_b.rsp_rdata, b_exp[k]);
            chk($sformatf("t6.rsp%0d.busy", k), 32'(bus_b.busy), 32'd0);
            tick();
        end
        bus_b.req_valid = 1'b0;
        #2;
        chk("t6.end.novalid", 32'(bus_b.rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
